// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline control unit.
// Hold vectors, divider sequencer state codes and default iteration count.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam int DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/pipe_div_seq.sv
// Multi-cycle divider sequencer: decides when a divide may leave EX.
// Drives the divider handshake pulses and the EX hold request.
module pipe_div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_div_req,
    input  logic flush_req,
    output logic div_start,
    output logic div_busy,
    output logic div_done,
    output logic ex_hold
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A flush aborts any divide in flight; no completion pulse follows.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_req) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (ex_div_req) begin
                        state_d = DIV_RUN;
                        cnt_d   = '0;
                    end
                end
                DIV_RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DIV_DONE;
                        cnt_d   = '0;
                    end
                end
                DIV_DONE: begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    logic run, hold_raw;

    assign run       = (state_q == DIV_RUN);
    assign hold_raw  = (state_q == DIV_IDLE && ex_div_req) || run;

    assign div_start = !rst && run && (cnt_q == '0);
    assign div_busy  = !rst && run;
    assign div_done  = !rst && (state_q == DIV_DONE);
    assign ex_hold   = !rst && hold_raw && !flush_req;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges ID stalls, flushes and divider holds
// into the per-stage hold vector and the flush strobe.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id,
    input  logic       ex_div_req,
    input  logic       flush_req,
    output logic [5:0] stall,
    output logic       flush,
    output logic       div_start,
    output logic       div_busy,
    output logic       div_done
);

    logic ex_hold;

    pipe_div_seq #(
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) u_div_seq (
        .clk       (clk),
        .rst       (rst),
        .ex_div_req(ex_div_req),
        .flush_req (flush_req),
        .div_start (div_start),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .ex_hold   (ex_hold)
    );

    // Priority: flush beats divider hold beats load-use hold.
    always_comb begin
        stall = STALL_NONE;
        flush = 1'b0;
        if (rst) begin
            stall = STALL_NONE;
        end else if (flush_req) begin
            flush = 1'b1;
        end else if (ex_hold) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed timing checks plus
// randomized traffic against a progress-count reference model.
module tb_pipe_ctrl;

    localparam int N = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       stallreq_id;
    logic       ex_div_req;
    logic       flush_req;
    logic [5:0] stall;
    logic       flush;
    logic       div_start;
    logic       div_busy;
    logic       div_done;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Model: pos = 0 when no divide in progress, 1..N while
    // iterating (iteration number), N+1 on the completion cycle.
    int pos = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.DIV_CYCLES(N), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .stallreq_id(stallreq_id),
        .ex_div_req (ex_div_req),
        .flush_req  (flush_req),
        .stall      (stall),
        .flush      (flush),
        .div_start  (div_start),
        .div_busy   (div_busy),
        .div_done   (div_done)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst)                        pos <= 0;
        else if (flush_req)             pos <= 0;
        else if (pos == 0)              pos <= ex_div_req ? 1 : 0;
        else if (pos == N + 1)          pos <= 0;
        else                            pos <= pos + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic       e_busy, e_start, e_done, e_hold, e_flush;
            logic [5:0] e_stall;
            e_busy  = !rst && pos >= 1 && pos <= N;
            e_start = !rst && pos == 1;
            e_done  = !rst && pos == N + 1;
            e_hold  = !flush_req && ((pos == 0 && ex_div_req) || e_busy);
            e_flush = !rst && flush_req;
            if (rst || flush_req) e_stall = 6'b000000;
            else if (e_hold)      e_stall = 6'b001111;
            else if (stallreq_id) e_stall = 6'b000111;
            else                  e_stall = 6'b000000;
            check("m_stall", 32'(stall), 32'(e_stall));
            check("m_flush", 32'(flush), 32'(e_flush));
            check("m_start", 32'(div_start), 32'(e_start));
            check("m_busy",  32'(div_busy), 32'(e_busy));
            check("m_done",  32'(div_done), 32'(e_done));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sc, ss, scyc, dd, dcyc, dcyc2, dstall, ex_cnt;
        rst = 1'b1;
        stallreq_id = 1'b0;
        ex_div_req  = 1'b0;
        flush_req   = 1'b0;
        #1 chk_en = 1;
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();

        // Idle and one-cycle load-use hold
        @(negedge clk);
        check("idle_stall", 32'(stall), 0);
        check("idle_done",  32'(div_done), 0);
        next_cycle();
        stallreq_id = 1'b1;
        @(negedge clk);
        check("ld_use_stall", 32'(stall), 32'h07);
        next_cycle();
        stallreq_id = 1'b0;
        @(negedge clk);
        check("ld_use_clear", 32'(stall), 0);
        next_cycle();

        // Single divide
        sc = 0; ss = 0; scyc = 0; dd = 0; dcyc = 0; dstall = -1;
        ex_div_req = 1'b1;
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            if (stall != 0) sc++;
            if (div_start) begin ss++; scyc = c; end
            if (div_done) begin dd++; dcyc = c; dstall = int'(stall); end
            next_cycle();
        end
        ex_div_req = 1'b0;
        check("div_stall_cycles", 32'(sc), 33);
        check("div_start_count",  32'(ss), 1);
        check("div_start_cycle",  32'(scyc), 2);
        check("div_done_count",   32'(dd), 1);
        check("div_done_cycle",   32'(dcyc), 34);
        check("div_done_stall",   32'(dstall), 0);
        repeat (2) next_cycle();

        // Flush at iteration cnt=10 (12th cycle of the sequence)
        ex_div_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 12) flush_req = 1'b1;
            @(negedge clk);
            if (c == 12) begin
                check("flush_stall", 32'(stall), 0);
                check("flush_flag",  32'(flush), 1);
            end
            next_cycle();
        end
        flush_req  = 1'b0;
        ex_div_req = 1'b0;
        @(negedge clk);
        check("post_flush_busy", 32'(div_busy), 0);
        dd = 0;
        for (int c = 0; c < N + 8; c++) begin
            @(negedge clk);
            if (div_done) dd++;
            next_cycle();
        end
        check("flush_no_done", 32'(dd), 0);

        // Two back-to-back divides with a load-use request held
        dd = 0; dcyc = 0; dcyc2 = 0; ex_cnt = 0; sc = 0;
        ex_div_req  = 1'b1;
        stallreq_id = 1'b1;
        for (int c = 1; c <= 2 * (N + 2); c++) begin
            @(negedge clk);
            if (stall == 6'h0f) ex_cnt++;
            if (div_done) begin
                dd++;
                if (dd == 1) dcyc = c; else dcyc2 = c;
                if (stall == 6'h07) sc++;
            end
            next_cycle();
        end
        ex_div_req  = 1'b0;
        stallreq_id = 1'b0;
        check("b2b_done_count",  32'(dd), 2);
        check("b2b_done_first",  32'(dcyc), 34);
        check("b2b_done_second", 32'(dcyc2), 68);
        check("b2b_ex_hold",     32'(ex_cnt), 66);
        check("done_ld_use",     32'(sc), 2);
        repeat (2) next_cycle();

        // Asynchronous reset mid-RUN
        ex_div_req = 1'b1;
        repeat (6) next_cycle();
        #2 rst = 1'b1;
        #1;
        check("arst_stall", 32'(stall), 0);
        check("arst_busy",  32'(div_busy), 0);
        check("arst_start", 32'(div_start), 0);
        next_cycle();
        rst = 1'b0;
        scyc = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (div_start) scyc = c;
            next_cycle();
        end
        check("arst_restart", 32'(scyc), 2);
        ex_div_req = 1'b0;
        repeat (N + 3) next_cycle();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            stallreq_id = ($urandom_range(0, 99) < 20);
            ex_div_req  = ($urandom_range(0, 99) < 60);
            flush_req   = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 3) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            next_cycle();
        end
        stallreq_id = 1'b0;
        ex_div_req  = 1'b0;
        flush_req   = 1'b0;
        repeat (2) next_cycle();
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
